// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - FSM state and engine mode enums
//   - iteration count and MUL/DIV function codes
//   - mag32: magnitude of a 32-bit operand, when treated as signed
package muldiv_ctrl_pkg;

  localparam int unsigned W_DATA   = 32;
  localparam int unsigned MD_ITERS = 32;

  localparam logic [4:0] FUNC_MUL = 5'h18;
  localparam logic [4:0] FUNC_DIV = 5'h1A;

  typedef enum logic {MD_IDLE, MD_RUN} muldiv_state_t;
  typedef enum logic {MODE_MUL, MODE_DIV} muldiv_mode_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> muldiv sequencer bundle.
//   master (EX side): op_valid/op_func/op_sign/op_a/op_b, hi_write/lo_write, flush
//   slave  (muldiv) : stall (comb), busy (reg), hi, lo
interface muldiv_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              op_valid;
  logic [4:0]        op_func;
  logic              op_sign;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              hi_write;
  logic              lo_write;
  logic              flush;
  logic              stall;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output op_valid, op_func, op_sign, op_a, op_b, hi_write, lo_write, flush,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  op_valid, op_func, op_sign, op_a, op_b, hi_write, lo_write, flush,
    output stall, busy, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl_step.sv
// muldiv_step: one combinational iteration of the muldiv engine.
//   mode     in  MODE_MUL: shift-add; MODE_DIV: restoring compare-subtract-shift
//   acc      in  64-bit working register ({acc_hi, multiplier} or {rem, quot})
//   opnd     in  multiplicand / divisor magnitude
//   acc_next out acc after one step
module muldiv_step
  import muldiv_ctrl_pkg::*;
(
  input  muldiv_mode_t mode,
  input  logic [63:0]  acc,
  input  logic [31:0]  opnd,
  output logic [63:0]  acc_next
);
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [31:0] diff;

  always_comb begin
    // MUL: conditionally add multiplicand into the top half, then shift right,
    // keeping the carry as the new MSB.
    sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    // DIV: shifted partial remainder needs 33 bits; the difference always fits 32.
    rem_sh = acc[63:31];
    diff   = rem_sh[31:0] - opnd;
    if (mode == MODE_MUL)
      acc_next = {sum, acc[31:1]};
    else if (rem_sh >= {1'b0, opnd})
      acc_next = {diff, acc[30:0], 1'b1};
    else
      acc_next = {rem_sh[31:0], acc[30:0], 1'b0};
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage multiply/divide sequencer owning HI/LO.
//   clk, rst_n  clock, asynchronous active-low reset
//   md (slave)  op request, MTHI/MTLO, flush in; stall, busy, hi, lo out
// Iterative ops take 32 RUN cycles after the accept cycle; stall covers the
// accept cycle and the first 31 RUN cycles so the issuer leaves EX once.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter bit          MUL_FAST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_ctrl_if.slave  md
);
  muldiv_state_t     state, state_nx;
  muldiv_mode_t      mode;
  logic [4:0]        cnt;
  logic [63:0]       acc, acc_step, p_fix, a_ext, b_ext, fast_p;
  logic [DATA_W-1:0] opnd, a_orig, q_fix, r_fix;
  logic              neg_q, neg_r, b_zero;
  logic              is_md, accept, fast_mul, last, finish;

  muldiv_step u_step (
    .mode     (mode),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  always_comb begin
    is_md    = (md.op_func == FUNC_MUL) || (md.op_func == FUNC_DIV);
    accept   = (state == MD_IDLE) && md.op_valid && !md.flush && is_md;
    fast_mul = MUL_FAST && accept && (md.op_func == FUNC_MUL);
    last     = (cnt == 5'(MD_ITERS - 1));
    finish   = (state == MD_RUN) && last && !md.flush;

    state_nx = state;
    case (state)
      MD_IDLE: if (accept && !fast_mul) state_nx = MD_RUN;
      MD_RUN:  if (md.flush || last)    state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase

    md.stall = rst_n && ((accept && !fast_mul) ||
                         ((state == MD_RUN) && !last && !md.flush));

    // Sign fixup applied to the final step result on the closing edge.
    p_fix = neg_q ? -acc_step : acc_step;
    q_fix = neg_q ? -acc_step[31:0]  : acc_step[31:0];
    r_fix = neg_r ? -acc_step[63:32] : acc_step[63:32];

    // Low 64 bits of a 64x64 product of extended operands give the right
    // answer for both signed and unsigned.
    a_ext  = {{32{md.op_sign & md.op_a[31]}}, md.op_a};
    b_ext  = {{32{md.op_sign & md.op_b[31]}}, md.op_b};
    fast_p = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_orig <= '0;
      mode   <= MODE_MUL;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      md.busy <= 1'b0;
      md.hi  <= '0;
      md.lo  <= '0;
    end else begin
      state   <= state_nx;
      md.busy <= (state_nx == MD_RUN);

      if (accept && !fast_mul) begin
        acc    <= {32'b0, mag32(md.op_a, md.op_sign)};
        opnd   <= mag32(md.op_b, md.op_sign);
        a_orig <= md.op_a;
        mode   <= (md.op_func == FUNC_DIV) ? MODE_DIV : MODE_MUL;
        neg_q  <= md.op_sign & (md.op_a[31] ^ md.op_b[31]);
        neg_r  <= md.op_sign & md.op_a[31];
        b_zero <= (md.op_b == '0);
        cnt    <= '0;
      end else if (state == MD_RUN) begin
        acc <= acc_step;
        cnt <= cnt + 5'd1;
      end

      if (fast_mul) begin
        {md.hi, md.lo} <= fast_p;
      end else if (finish) begin
        if (mode == MODE_MUL) begin
          {md.hi, md.lo} <= p_fix;
        end else if (b_zero) begin
          md.hi <= a_orig;
          md.lo <= '1;
        end else begin
          md.hi <= r_fix;
          md.lo <= q_fix;
        end
      end else if ((state == MD_IDLE) && md.op_valid && !md.flush) begin
        if (md.hi_write) md.hi <= md.op_a;
        if (md.lo_write) md.lo <= md.op_a;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed + randomized bench for muldiv_ctrl; reference results come from
// plain 64-bit arithmetic on the operands.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.DATA_W(32)) md ();

  muldiv_ctrl #(.DATA_W(32), .MUL_FAST(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    md.op_valid = 1'b0;
    md.op_func  = 5'd0;
    md.op_sign  = 1'b0;
    md.op_a     = '0;
    md.op_b     = '0;
    md.hi_write = 1'b0;
    md.lo_write = 1'b0;
    md.flush    = 1'b0;
  endtask

  // Expected HI/LO from ordinary arithmetic.
  task automatic ref_model(input logic is_div, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] ax, bx, p;
    longint x, y, q, r;
    if (!is_div) begin
      ax = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      bx = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ax * bx;
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      q = x / y;
      r = x % y;
      el = q[31:0];
      eh = r[31:0];
    end
  endtask

  // Issue an op and hold it in EX while stalled; returns stall-high cycle count.
  task automatic run_op(input logic [4:0] f, input logic s,
                        input logic [31:0] a, input logic [31:0] b, output int stalls);
    @(negedge clk);
    md.op_valid = 1'b1;
    md.op_func  = f;
    md.op_sign  = s;
    md.op_a     = a;
    md.op_b     = b;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (i == 1) chk("busy_run", 64'(md.busy), 64'd1);
      if (md.stall !== 1'b1) break;
      stalls++;
      @(negedge clk);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic check_op(input string tag, input logic [4:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
    int st;
    logic [31:0] eh, el;
    ref_model(f == FUNC_DIV, s, a, b, eh, el);
    run_op(f, s, a, b, st);
    #1;
    chk({tag, " stalls"}, 64'(st), 64'd32);
    chk({tag, " hi"}, 64'(md.hi), 64'(eh));
    chk({tag, " lo"}, 64'(md.lo), 64'(el));
    chk({tag, " busy"}, 64'(md.busy), 64'd0);
  endtask

  initial begin
    logic [4:0]  f;
    logic        s;
    logic [31:0] a, b;

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst stall", 64'(md.stall), 64'd0);
    chk("rst busy",  64'(md.busy),  64'd0);
    chk("rst hi",    64'(md.hi),    64'd0);
    chk("rst lo",    64'(md.lo),    64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check_op("umul_max", FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("umul_max hi const", 64'(md.hi), 64'h0000_0000_FFFF_FFFE);
    chk("umul_max lo const", 64'(md.lo), 64'h0000_0000_0000_0001);
    check_op("smul_m3x7", FUNC_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7);
    chk("mfhi after smul", 64'(md.hi), 64'h0000_0000_FFFF_FFFF);
    check_op("sdiv_m7d2",  FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("sdiv lo const", 64'(md.lo), 64'h0000_0000_FFFF_FFFD);
    check_op("udiv_100d7", FUNC_DIV, 1'b0, 32'd100, 32'd7);
    check_op("div_by0",    FUNC_DIV, 1'b1, 32'h0000_1234, 32'd0);
    check_op("sdiv_ovf",   FUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("mul_zero",   FUNC_MUL, 1'b1, 32'd0, 32'h1234_5678);

    // MTHI then MTLO, then flush a MUL at cnt==10.
    @(negedge clk); md.op_valid = 1'b1; md.hi_write = 1'b1; md.op_a = 32'hAA;
    @(negedge clk); idle_inputs(); md.op_valid = 1'b1; md.lo_write = 1'b1; md.op_a = 32'h55;
    @(negedge clk); idle_inputs();
    #1;
    chk("mthi", 64'(md.hi), 64'hAA);
    chk("mtlo", 64'(md.lo), 64'h55);
    md.op_valid = 1'b1; md.op_func = FUNC_MUL; md.op_a = 32'd5; md.op_b = 32'd5;
    repeat (11) @(negedge clk);
    md.flush = 1'b1;
    #1;
    chk("flush stall", 64'(md.stall), 64'd0);
    @(negedge clk); idle_inputs();
    #1;
    chk("flush busy", 64'(md.busy), 64'd0);
    chk("flush hi", 64'(md.hi), 64'hAA);
    chk("flush lo", 64'(md.lo), 64'h55);
    check_op("mul_2x3", FUNC_MUL, 1'b0, 32'd2, 32'd3);

    // Flush in IDLE blocks accept.
    @(negedge clk);
    md.op_valid = 1'b1; md.op_func = FUNC_DIV; md.op_a = 32'd9; md.op_b = 32'd3; md.flush = 1'b1;
    #1;
    chk("idle flush stall", 64'(md.stall), 64'd0);
    @(negedge clk); idle_inputs();
    #1;
    chk("idle flush busy", 64'(md.busy), 64'd0);

    // MTHI and MTLO together.
    @(negedge clk); md.op_valid = 1'b1; md.hi_write = 1'b1; md.lo_write = 1'b1; md.op_a = 32'h1357;
    @(negedge clk); idle_inputs();
    #1;
    chk("mt both hi", 64'(md.hi), 64'h1357);
    chk("mt both lo", 64'(md.lo), 64'h1357);

    // Flush in the final RUN cycle aborts the write.
    md.op_valid = 1'b1; md.op_func = FUNC_DIV; md.op_a = 32'd77; md.op_b = 32'd5;
    repeat (32) @(negedge clk);
    md.flush = 1'b1;
    #1;
    chk("t32 flush stall", 64'(md.stall), 64'd0);
    @(negedge clk); idle_inputs();
    #1;
    chk("t32 flush hi", 64'(md.hi), 64'h1357);
    chk("t32 flush lo", 64'(md.lo), 64'h1357);
    chk("t32 flush busy", 64'(md.busy), 64'd0);

    // Asynchronous reset mid-op at cnt==20.
    md.op_valid = 1'b1; md.op_func = FUNC_DIV; md.op_a = 32'd1000; md.op_b = 32'd3;
    repeat (21) @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("midrst hi",    64'(md.hi),    64'd0);
    chk("midrst lo",    64'(md.lo),    64'd0);
    chk("midrst busy",  64'(md.busy),  64'd0);
    chk("midrst stall", 64'(md.stall), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    check_op("post_rst", FUNC_DIV, 1'b0, 32'd1000, 32'd3);

    for (int n = 0; n < 24; n++) begin
      f = ($urandom_range(0, 1) == 0) ? FUNC_MUL : FUNC_DIV;
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      check_op($sformatf("rnd%0d", n), f, s, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
